// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_ctrl
//  Description : Overlapping Moore detector for the serial pattern 1-0-1-1,
//                with a saturating detection counter and a synchronous
//                soft clear. Reset is asynchronous, active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             in_valid,
    input  logic             clr,
    output logic             det,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] det_cnt,
    output logic             cnt_sat
);

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t cur_state;
    state_t nxt_state;
    logic   entering;

    // Next-state decode; invalid cycles hold, unused codes fall back to S0.
    always_comb begin
        nxt_state = S0;
        case (cur_state)
            S0:      nxt_state = !in_valid ? cur_state : (d ? S1    : S0);
            S1:      nxt_state = !in_valid ? cur_state : (d ? S1    : S10);
            S10:     nxt_state = !in_valid ? cur_state : (d ? S101  : S0);
            S101:    nxt_state = !in_valid ? cur_state : (d ? S1011 : S10);
            S1011:   nxt_state = !in_valid ? cur_state : (d ? S1    : S10);
            default: nxt_state = S0;
        endcase
    end

    // A detection is counted only on the edge that enters S1011, so a
    // stretched stay in S1011 (in_valid low) is not counted again.
    assign entering = (nxt_state == S1011) && (cur_state != S1011);

    // State, detect flag and counter registers; clr outranks the data path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= S0;
            det       <= 1'b0;
            det_cnt   <= '0;
        end else if (clr) begin
            cur_state <= S0;
            det       <= 1'b0;
            det_cnt   <= '0;
        end else begin
            cur_state <= nxt_state;
            det       <= (nxt_state == S1011);
            if (entering && (det_cnt != c_cnt_max)) begin
                det_cnt <= det_cnt + c_cnt_one;
            end
        end
    end

    assign state   = cur_state;
    assign cnt_sat = (det_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_ctrl
//  Description : Self-checking bench for seq_detect_ctrl. Two instances
//                (CNT_W=8 and CNT_W=2) share stimulus; a pattern-matching
//                reference model tracks expected state, flag and counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;

    logic       clk;
    logic       rst;
    logic       d;
    logic       in_valid;
    logic       clr;
    logic       det_a;
    logic [2:0] state_a;
    logic [7:0] cnt_a;
    logic       sat_a;
    logic       det_b;
    logic [2:0] state_b;
    logic [1:0] cnt_b;
    logic       sat_b;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: last valid bits since reset/clear, and counts.
    bit hist[$];
    int m_len  = 0;
    int m_cnt8 = 0;
    int m_cnt2 = 0;
    int pat[4] = '{1, 0, 1, 1};

    seq_detect_ctrl dut_a (
        .clk      (clk),
        .rst      (rst),
        .d        (d),
        .in_valid (in_valid),
        .clr      (clr),
        .det      (det_a),
        .state    (state_a),
        .det_cnt  (cnt_a),
        .cnt_sat  (sat_a)
    );

    seq_detect_ctrl #(.CNT_W(2)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .d        (d),
        .in_valid (in_valid),
        .clr      (clr),
        .det      (det_b),
        .state    (state_b),
        .det_cnt  (cnt_b),
        .cnt_sat  (sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Longest suffix of the received bits that is a prefix of 1011.
    function automatic int match_len();
        for (int l = 4; l >= 1; l--) begin
            if (hist.size() >= l) begin
                bit ok;
                ok = 1'b1;
                for (int k = 0; k < l; k++)
                    if (int'(hist[hist.size() - l + k]) != pat[k]) ok = 1'b0;
                if (ok) return l;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_len  = 0;
        m_cnt8 = 0;
        m_cnt2 = 0;
    endtask

    task automatic model_edge(input logic b, input logic v, input logic c);
        int old_len;
        if (c) begin
            model_reset();
        end else if (v) begin
            old_len = m_len;
            hist.push_back(b);
            if (hist.size() > 4) void'(hist.pop_front());
            m_len = match_len();
            if (m_len == 4 && old_len != 4) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},  32'(state_a), 32'(m_len));
        chk({tag, ".det"},    32'(det_a),   32'(m_len == 4));
        chk({tag, ".cnt"},    32'(cnt_a),   32'(m_cnt8));
        chk({tag, ".sat"},    32'(sat_a),   32'(m_cnt8 == 255));
        chk({tag, ".state2"}, 32'(state_b), 32'(m_len));
        chk({tag, ".det2"},   32'(det_b),   32'(m_len == 4));
        chk({tag, ".cnt2"},   32'(cnt_b),   32'(m_cnt2));
        chk({tag, ".sat2"},   32'(sat_b),   32'(m_cnt2 == 3));
    endtask

    // One clock: drive, step the model at the edge, check 1 ns later.
    task automatic step(input string tag, input logic b, input logic v, input logic c);
        d        = b;
        in_valid = v;
        clr      = c;
        @(posedge clk);
        model_edge(b, v, c);
        #1;
        check_all(tag);
    endtask

    // Pull reset low between edges and confirm outputs clear before an edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        #2 rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        d        = 1'b0;
        in_valid = 1'b0;
        clr      = 1'b0;
        #1;
        check_all("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst = 1'b1;

        // Basic match straight out of reset.
        step("b1", 1'b1, 1'b1, 1'b0);
        step("b2", 1'b0, 1'b1, 1'b0);
        step("b3", 1'b1, 1'b1, 1'b0);
        step("b4", 1'b1, 1'b1, 1'b0);
        chk("basic.det", 32'(det_a), 32'd1);
        chk("basic.cnt", 32'(cnt_a), 32'd1);
        chk("basic.state", 32'(state_a), 32'd4);

        // Overlap: 1,0,1,1,0,1,1.
        step("ov_clr", 1'b0, 1'b0, 1'b1);
        step("ov1", 1'b1, 1'b1, 1'b0);
        step("ov2", 1'b0, 1'b1, 1'b0);
        step("ov3", 1'b1, 1'b1, 1'b0);
        step("ov4", 1'b1, 1'b1, 1'b0);
        step("ov5", 1'b0, 1'b1, 1'b0);
        chk("ovl.s5", 32'(state_a), 32'd2);
        step("ov6", 1'b1, 1'b1, 1'b0);
        step("ov7", 1'b1, 1'b1, 1'b0);
        chk("ovl.det", 32'(det_a), 32'd1);
        chk("ovl.cnt", 32'(cnt_a), 32'd2);

        // Gating: in_valid low holds S101 even with d=1.
        step("g_clr", 1'b0, 1'b0, 1'b1);
        step("g1", 1'b1, 1'b1, 1'b0);
        step("g2", 1'b0, 1'b1, 1'b0);
        step("g3", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("gap", 1'b1, 1'b0, 1'b0);
            chk("gap.state", 32'(state_a), 32'd3);
            chk("gap.det", 32'(det_a), 32'd0);
        end
        step("g4", 1'b1, 1'b1, 1'b0);
        chk("gate.det", 32'(det_a), 32'd1);
        // Stretched stay in S1011 keeps det high without recounting.
        step("g_hold", 1'b0, 1'b0, 1'b0);
        chk("hold.det", 32'(det_a), 32'd1);
        chk("hold.cnt", 32'(cnt_a), 32'd1);

        // Clear on the same edge as the 4th matching bit.
        step("c_clr", 1'b0, 1'b0, 1'b1);
        step("c1", 1'b1, 1'b1, 1'b0);
        step("c2", 1'b0, 1'b1, 1'b0);
        step("c3", 1'b1, 1'b1, 1'b0);
        step("c4", 1'b1, 1'b1, 1'b1);
        chk("clr.state", 32'(state_a), 32'd0);
        chk("clr.det", 32'(det_a), 32'd0);
        chk("clr.cnt", 32'(cnt_a), 32'd0);

        // Saturation of the 2-bit instance after 5 overlapping matches.
        step("s_clr", 1'b0, 1'b0, 1'b1);
        step("s1", 1'b1, 1'b1, 1'b0);
        step("s2", 1'b0, 1'b1, 1'b0);
        step("s3", 1'b1, 1'b1, 1'b0);
        step("s4", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("sa", 1'b0, 1'b1, 1'b0);
            step("sb", 1'b1, 1'b1, 1'b0);
            step("sc", 1'b1, 1'b1, 1'b0);
        end
        chk("sat2.cnt", 32'(cnt_b), 32'd3);
        chk("sat2.flag", 32'(sat_b), 32'd1);
        chk("sat8.cnt", 32'(cnt_a), 32'd5);

        // Async reset mid-sequence aborts the partial match.
        step("r_clr", 1'b0, 1'b0, 1'b1);
        step("r1", 1'b1, 1'b1, 1'b0);
        step("r2", 1'b0, 1'b1, 1'b0);
        step("r3", 1'b1, 1'b1, 1'b0);
        chk("ar.pre", 32'(state_a), 32'd3);
        async_reset("ar");
        chk("ar.state", 32'(state_a), 32'd0);
        step("r4", 1'b1, 1'b1, 1'b0);
        step("r5", 1'b1, 1'b1, 1'b0);
        chk("ar.nodet", 32'(det_a), 32'd0);
        chk("ar.s1", 32'(state_a), 32'd1);

        // Long burst to saturate the 8-bit counter.
        step("l_clr", 1'b0, 1'b0, 1'b1);
        step("l1", 1'b1, 1'b1, 1'b0);
        step("l2", 1'b0, 1'b1, 1'b0);
        step("l3", 1'b1, 1'b1, 1'b0);
        step("l4", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 258; i++) begin
            step("la", 1'b0, 1'b1, 1'b0);
            step("lb", 1'b1, 1'b1, 1'b0);
            step("lc", 1'b1, 1'b1, 1'b0);
        end
        chk("sat8.max", 32'(cnt_a), 32'd255);
        chk("sat8.flag", 32'(sat_a), 32'd1);

        // Randomized traffic with occasional clears and async resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step("rnd", 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 59) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
